range_finder_ram_arbiter: RTL and testbench
===========================================

Name: range_finder_ram_arbiter

Overview:
- Shares the single-port 32K x 32 on-chip RAM between two Avalon-MM style requesters.
- Port 0 is the range-capture DMA writer; port 1 is the Nios CPU data master.
- Grants one transaction per cycle with round-robin arbitration and a bounded burst hold, drives the RAM's chipselect/write/address/byteenable, and returns read data with a fixed 1-cycle latency.
- Sits between the two masters and the RAM instance; the RAM's clken is tied high outside this block.

Parameters:
- ADDR_W, 15, word-address width of the RAM (32768 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 8, max consecutive grants to one port while the other port is requesting (range 1..255).
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties (MAX_HOLD still applies to port 0).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- freeze  in  1  when high, no new grants; a read already in flight still completes
- m0_address  in  ADDR_W  port 0 word address
- m0_read / m0_write  in  1 each  port 0 request strobes
- m0_writedata  in  DATA_W  port 0 write data
- m0_byteenable  in  DATA_W/8  port 0 byte enables
- m0_waitrequest  out  1  high = port 0 request not accepted this cycle
- m0_readdata  out  DATA_W  port 0 read data
- m0_readdatavalid  out  1  port 0 read data valid
- m1_*  same set as m0_* for port 1
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_chipselect / ram_write  out  1 each  to RAM
- ram_writedata  out  DATA_W  to RAM writedata
- ram_readdata  in  DATA_W  from RAM readdata (unregistered output, valid the cycle after address)
- proto_err  out  1  sticky flag: read and write asserted together on one port

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0 except mX_waitrequest = 1.
  - FSM returns to IDLE, hold counter = 0, last_owner = 1 (so port 0 wins the first tie).
  - Any pending readdatavalid is cancelled.
- Request definition: reqX = mX_read | mX_write.
- Handshake:
  - mX_waitrequest is combinational: it is 0 exactly in the cycle the grant selects port X and freeze = 0.
  - The transfer occurs in the cycle where reqX = 1 and waitrequest = 0.
  - A master holds its request stable while waitrequest = 1.
- RAM drive in an accept cycle:
  - ram_chipselect = 1; ram_address, ram_byteenable and ram_writedata are muxed from the winning port.
  - ram_write = mX_write.
  - No accept means chipselect = 0 and write = 0.
- Read latency:
  - A read accepted in cycle t gives mX_readdatavalid = 1 in cycle t+1, with mX_readdata = ram_readdata.
  - Implemented as a 1-deep registered tag {valid, port}.
  - Back-to-back reads are allowed on every cycle.
  - readdata of the non-valid port is held at its last value.
- Write: completes in the accept cycle; there is no response.
- Arbitration, FSM states IDLE, OWN0, OWN1 (registered):
  - IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the port != last_owner (FIXED_PRIO=1: port 0).
  - OWNx: continue granting x while reqx = 1 and (other port idle or hold < MAX_HOLD).
  - OWNx: switch to the other port when reqx = 0 with the other requesting, or when hold = MAX_HOLD with the other requesting.
  - OWNx: go to IDLE when no requests.
  - Hold counter: increments per grant to the same owner, resets to 1 on owner change, saturates at MAX_HOLD. MAX_HOLD=1 gives strict alternation.
  - The grant decision for cycle t uses the cycle-t requests and registered state, so a lone requester gets zero-wait access every cycle.
- freeze = 1:
  - Both waitrequests = 1 and the FSM state and hold counter are frozen.
  - An in-flight readdatavalid still fires.
- Read + write asserted together on one port:
  - Treated as a write, the read is dropped, proto_err set.
  - proto_err is cleared only by reset.
- Reset during an in-flight read: no readdatavalid is produced.

Decomposition:
- Package range_finder_ram_pkg: ADDR_W/DATA_W defaults, FSM state enum {IDLE, OWN0, OWN1}, read-tag struct {valid, port}.
- One natural sub-module: range_finder_rr_grant (2-way round-robin and hold counter, outputs grant and state); the top level holds the muxes and the read-tag pipeline.

Test Plan:
- Single requester: m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then m0 reads 0x0010 -> waitrequest 0 in both cycles; readdatavalid in the cycle after the read with m0_readdata = 0xDEADBEEF.
- Byte enables: write 0x11223344 to address 0x7FFF, then write 0xAABBCCDD with byteenable 0x5, then read -> 0x11BB33DD.
- Contention, MAX_HOLD=2, both ports streaming reads -> grants go 0,0,1,1,0,0 (first tie to port 0); each readdatavalid appears 1 cycle after its grant on the correct port.
- freeze held 3 cycles while a read from cycle t is in flight -> readdatavalid fires at t+1; no chipselect for 3 cycles; arbitration resumes with the same owner and hold count.
- m1 asserts read and write together with writedata 0x5 at address 0x20 -> RAM write occurs, no readdatavalid, proto_err = 1 and stays 1 until reset.
- Async reset asserted mid-cycle right after a read accept -> readdatavalid never asserts; all outputs at reset values immediately; first post-reset tie goes to port 0.

Source files
------------

// File: rtl/range_finder_ram_pkg.sv
// Shared types for the range-finder RAM arbiter.
// State encoding, read-tag bundle and hold-counter helper.
package range_finder_ram_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam int HOLD_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    function automatic logic [HOLD_W-1:0] hold_inc(
        input logic [HOLD_W-1:0] h,
        input logic [HOLD_W-1:0] hmax
    );
        return (h >= hmax) ? hmax : h + 1'b1;
    endfunction

endpackage

// File: rtl/range_finder_rr_grant.sv
// Two-way round-robin grant with bounded burst hold.
// Decision is combinational on live requests and registered state.
module range_finder_rr_grant
    import range_finder_ram_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_freeze,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant_valid,
    output logic o_grant_port
);

    localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

    arb_state_t        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_last;

    logic w_gv;
    logic w_gp;
    logic w_own;
    logic w_req_own;
    logic w_req_oth;

    assign w_own     = (r_state == OWN1);
    assign w_req_own = w_own ? i_req1 : i_req0;
    assign w_req_oth = w_own ? i_req0 : i_req1;

    always_comb begin
        w_gv = 1'b0;
        w_gp = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    w_gv = 1'b1;
                    w_gp = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
                end else if (i_req0) begin
                    w_gv = 1'b1;
                    w_gp = 1'b0;
                end else if (i_req1) begin
                    w_gv = 1'b1;
                    w_gp = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (w_req_own && (!w_req_oth || r_hold < MAX_H)) begin
                    w_gv = 1'b1;
                    w_gp = w_own;
                end else if (w_req_oth) begin
                    w_gv = 1'b1;
                    w_gp = ~w_own;
                end
            end
            default: begin
                w_gv = 1'b0;
                w_gp = 1'b0;
            end
        endcase
    end

    // Hold counts consecutive grants to the current owner; 0 only in IDLE.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= 1'b1;
        end else if (!i_freeze) begin
            if (w_gv) begin
                r_state <= w_gp ? OWN1 : OWN0;
                if (r_state != IDLE && w_gp == w_own)
                    r_hold <= hold_inc(r_hold, MAX_H);
                else
                    r_hold <= HOLD_W'(1);
                r_last <= w_gp;
            end else begin
                r_state <= IDLE;
                r_hold  <= '0;
            end
        end
    end

    assign o_grant_valid = w_gv;
    assign o_grant_port  = w_gp;

endmodule

// File: rtl/range_finder_ram_arbiter.sv
// Shares one single-port RAM between the capture DMA (port 0)
// and the CPU data master (port 1); 1-cycle read latency.
module range_finder_ram_arbiter
    import range_finder_ram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_HOLD   = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic                proto_err
);

    logic w_req0;
    logic w_req1;
    logic w_gv;
    logic w_gp;
    logic w_acc;
    logic w_acc0;
    logic w_acc1;
    logic w_rdv0;
    logic w_rdv1;

    rd_tag_t w_tag_nxt;
    rd_tag_t r_tag;

    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_perr;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    range_finder_rr_grant #(
        .MAX_HOLD  (MAX_HOLD),
        .FIXED_PRIO(FIXED_PRIO)
    ) u_grant (
        .clk          (clk),
        .i_reset      (reset),
        .i_freeze     (freeze),
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .o_grant_valid(w_gv),
        .o_grant_port (w_gp)
    );

    // Reset gates the accept so outputs are idle while reset is held.
    assign w_acc  = w_gv & ~freeze & ~reset;
    assign w_acc0 = w_acc & ~w_gp;
    assign w_acc1 = w_acc & w_gp;

    assign m0_waitrequest = ~w_acc0;
    assign m1_waitrequest = ~w_acc1;

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        unique case (1'b1)
            w_acc0: begin
                ram_chipselect = 1'b1;
                ram_write      = m0_write;
                ram_address    = m0_address;
                ram_byteenable = m0_byteenable;
                ram_writedata  = m0_writedata;
            end
            w_acc1: begin
                ram_chipselect = 1'b1;
                ram_write      = m1_write;
                ram_address    = m1_address;
                ram_byteenable = m1_byteenable;
                ram_writedata  = m1_writedata;
            end
            default: begin
                ram_chipselect = 1'b0;
            end
        endcase
    end

    // A combined read+write is a write; its read half gets no tag.
    always_comb begin
        w_tag_nxt.port  = w_gp;
        w_tag_nxt.valid = w_acc & (w_gp ? (m1_read & ~m1_write)
                                        : (m0_read & ~m0_write));
    end

    assign w_rdv0 = r_tag.valid & ~r_tag.port;
    assign w_rdv1 = r_tag.valid & r_tag.port;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_tag <= w_tag_nxt;
            if (w_rdv0)
                r_rdata0 <= ram_readdata;
            if (w_rdv1)
                r_rdata1 <= ram_readdata;
            if ((m0_read & m0_write) | (m1_read & m1_write))
                r_perr <= 1'b1;
        end
    end

    assign m0_readdatavalid = w_rdv0;
    assign m1_readdatavalid = w_rdv1;
    assign m0_readdata      = w_rdv0 ? ram_readdata : r_rdata0;
    assign m1_readdata      = w_rdv1 ? ram_readdata : r_rdata1;
    assign proto_err        = r_perr;

endmodule

// File: tb/tb_range_finder_ram_arbiter.sv
// Directed vector bench for range_finder_ram_arbiter (MAX_HOLD=2)
// with a behavioural 32K x 32 RAM.
module tb_range_finder_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic [14:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [14:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [14:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    range_finder_ram_arbiter #(
        .ADDR_W    (15),
        .DATA_W    (32),
        .MAX_HOLD  (2),
        .FIXED_PRIO(0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .freeze          (freeze),
        .m0_address      (m0_address),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_writedata    (m0_writedata),
        .m0_byteenable   (m0_byteenable),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address      (m1_address),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_writedata    (m1_writedata),
        .m1_byteenable   (m1_byteenable),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address     (ram_address),
        .ram_byteenable  (ram_byteenable),
        .ram_chipselect  (ram_chipselect),
        .ram_write       (ram_write),
        .ram_writedata   (ram_writedata),
        .ram_readdata    (ram_readdata),
        .proto_err       (proto_err)
    );

    // RAM model: byte-enabled write, registered read data.
    logic [31:0] mem [0:32767];
    logic [31:0] ram_q = '0;
    assign ram_readdata = ram_q;

    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b])
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= mem[ram_address];
            end
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [14:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic        r1, w1;
        logic [14:0] a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic        frz;
        logic        ew0, ew1, ecs, ewr;
        logic [14:0] ea;
        logic        ev0, ev1;
        logic [31:0] erd;
        logic        ep;
    } vec_t;

    function automatic vec_t mk(
        logic r0, logic w0, logic [14:0] a0, logic [31:0] d0, logic [3:0] b0,
        logic r1, logic w1, logic [14:0] a1, logic [31:0] d1, logic [3:0] b1,
        logic frz, logic ew0, logic ew1, logic ecs, logic ewr, logic [14:0] ea,
        logic ev0, logic ev1, logic [31:0] erd, logic ep
    );
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
        v.frz = frz; v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewr = ewr;
        v.ea = ea; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_read = 0; m1_write = 0; m1_address = '0;
        m1_writedata = '0; m1_byteenable = '0;
        freeze = 0;
    endtask

    vec_t tv [23];

    initial begin
        tv[0]  = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        0,0,0,0);
        tv[1]  = mk(0,1,'h10,'hDEADBEEF,'hF, 0,0,0,0,0,               0, 0,1,1,1,'h10,     0,0,0,0);
        tv[2]  = mk(1,0,'h10,0,'hF,        0,0,0,0,0,                 0, 0,1,1,0,'h10,     0,0,0,0);
        tv[3]  = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        1,0,'hDEADBEEF,0);
        tv[4]  = mk(0,0,0,0,0,             0,1,'h7FFF,'h11223344,'hF, 0, 1,0,1,1,'h7FFF,   0,0,0,0);
        tv[5]  = mk(0,0,0,0,0,             0,1,'h7FFF,'hAABBCCDD,'h5, 0, 1,0,1,1,'h7FFF,   0,0,0,0);
        tv[6]  = mk(0,0,0,0,0,             1,0,'h7FFF,0,'hF,          0, 1,0,1,0,'h7FFF,   0,0,0,0);
        tv[7]  = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        0,1,'h11BB33DD,0);
        tv[8]  = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 0,1,1,0,'h10,     0,0,0,0);
        tv[9]  = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 0,1,1,0,'h10,     1,0,'hDEADBEEF,0);
        tv[10] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 1,0,1,0,'h7FFF,   1,0,'hDEADBEEF,0);
        tv[11] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 1,0,1,0,'h7FFF,   0,1,'h11BB33DD,0);
        tv[12] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 0,1,1,0,'h10,     0,1,'h11BB33DD,0);
        tv[13] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 0,1,1,0,'h10,     1,0,'hDEADBEEF,0);
        tv[14] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          1, 1,1,0,0,0,        1,0,'hDEADBEEF,0);
        tv[15] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          1, 1,1,0,0,0,        0,0,0,0);
        tv[16] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          1, 1,1,0,0,0,        0,0,0,0);
        tv[17] = mk(1,0,'h10,0,'hF,        1,0,'h7FFF,0,'hF,          0, 1,0,1,0,'h7FFF,   0,0,0,0);
        tv[18] = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        0,1,'h11BB33DD,0);
        tv[19] = mk(0,0,0,0,0,             1,1,'h20,'h5,'hF,          0, 1,0,1,1,'h20,     0,0,0,0);
        tv[20] = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        0,0,0,1);
        tv[21] = mk(1,0,'h20,0,'hF,        0,0,0,0,0,                 0, 0,1,1,0,'h20,     0,0,0,1);
        tv[22] = mk(0,0,0,0,0,             0,0,0,0,0,                 0, 1,1,0,0,0,        1,0,'h5,1);

        // Reset state, with a request present that must not be granted.
        reset = 1'b1;
        idle_inputs();
        m0_read = 1'b1;
        #12;
        chk("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
        chk("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
        chk("rst_cs", {31'd0, ram_chipselect}, 32'd0);
        chk("rst_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        m0_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            m0_read = tv[i].r0; m0_write = tv[i].w0; m0_address = tv[i].a0;
            m0_writedata = tv[i].d0; m0_byteenable = tv[i].b0;
            m1_read = tv[i].r1; m1_write = tv[i].w1; m1_address = tv[i].a1;
            m1_writedata = tv[i].d1; m1_byteenable = tv[i].b1;
            freeze = tv[i].frz;
            @(negedge clk);
            chk($sformatf("v%0d_wait0", i), {31'd0, m0_waitrequest}, {31'd0, tv[i].ew0});
            chk($sformatf("v%0d_wait1", i), {31'd0, m1_waitrequest}, {31'd0, tv[i].ew1});
            chk($sformatf("v%0d_cs", i), {31'd0, ram_chipselect}, {31'd0, tv[i].ecs});
            chk($sformatf("v%0d_we", i), {31'd0, ram_write}, {31'd0, tv[i].ewr});
            if (tv[i].ecs)
                chk($sformatf("v%0d_addr", i), {17'd0, ram_address}, {17'd0, tv[i].ea});
            if (tv[i].ewr)
                chk($sformatf("v%0d_wdata", i), ram_writedata,
                    tv[i].ew0 ? tv[i].d1 : tv[i].d0);
            chk($sformatf("v%0d_rdv0", i), {31'd0, m0_readdatavalid}, {31'd0, tv[i].ev0});
            chk($sformatf("v%0d_rdv1", i), {31'd0, m1_readdatavalid}, {31'd0, tv[i].ev1});
            if (tv[i].ev0)
                chk($sformatf("v%0d_rd0", i), m0_readdata, tv[i].erd);
            if (tv[i].ev1)
                chk($sformatf("v%0d_rd1", i), m1_readdata, tv[i].erd);
            chk($sformatf("v%0d_perr", i), {31'd0, proto_err}, {31'd0, tv[i].ep});
        end

        // Async reset right after a read is accepted, before its data edge.
        @(posedge clk);
        #1;
        idle_inputs();
        m0_read = 1'b1;
        m0_address = 15'h10;
        m0_byteenable = 4'hF;
        @(negedge clk);
        chk("ar_accept", {31'd0, m0_waitrequest}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_wait0", {31'd0, m0_waitrequest}, 32'd1);
        chk("ar_wait1", {31'd0, m1_waitrequest}, 32'd1);
        chk("ar_cs", {31'd0, ram_chipselect}, 32'd0);
        chk("ar_perr", {31'd0, proto_err}, 32'd0);
        chk("ar_rd0", m0_readdata, 32'd0);
        chk("ar_rd1", m1_readdata, 32'd0);
        m0_read = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("ar_rdv0_c%0d", c), {31'd0, m0_readdatavalid}, 32'd0);
            chk($sformatf("ar_rdv1_c%0d", c), {31'd0, m1_readdatavalid}, 32'd0);
        end
        reset = 1'b0;

        // First tie after reset goes to port 0.
        @(posedge clk);
        #1;
        m0_read = 1'b1; m0_address = 15'h10; m0_byteenable = 4'hF;
        m1_read = 1'b1; m1_address = 15'h7FFF; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("pr_wait0", {31'd0, m0_waitrequest}, 32'd0);
        chk("pr_wait1", {31'd0, m1_waitrequest}, 32'd1);
        chk("pr_rdv0_early", {31'd0, m0_readdatavalid}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("pr_rdv0", {31'd0, m0_readdatavalid}, 32'd1);
        chk("pr_rd0", m0_readdata, 32'hDEADBEEF);
        chk("pr_rdv1", {31'd0, m1_readdatavalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
